// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory arbiter slice.
package dmem_pkg;

    localparam int unsigned REQ_ADDR_W = 9;
    localparam int unsigned REQ_DATA_W = 32;
    localparam int unsigned F3_W       = 3;
    localparam int unsigned CNT_W      = 4;

    typedef enum logic {
        ARB  = 1'b0,
        LOCK = 1'b1
    } arb_state_t;

    localparam logic [F3_W-1:0] F3_LB  = 3'b000;
    localparam logic [F3_W-1:0] F3_LH  = 3'b001;
    localparam logic [F3_W-1:0] F3_LW  = 3'b010;
    localparam logic [F3_W-1:0] F3_LBU = 3'b100;
    localparam logic [F3_W-1:0] F3_SB  = 3'b000;
    localparam logic [F3_W-1:0] F3_SH  = 3'b001;
    localparam logic [F3_W-1:0] F3_SW  = 3'b010;

    typedef struct packed {
        logic                  we;
        logic [REQ_ADDR_W-1:0] addr;
        logic [REQ_DATA_W-1:0] wdata;
        logic [F3_W-1:0]       funct3;
    } mem_req_t;

endpackage

// File: rtl/dmem_rsp_reg.sv
// Per-port load response register: captures memory read data at the end of a load grant.
module dmem_rsp_reg #(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              capture,
    input  logic [DATA_W-1:0] mem_rd,
    output logic              rvalid,
    output logic [DATA_W-1:0] rdata
);

    // rdata keeps the last loaded word until the next load on this port
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rvalid <= 1'b0;
            rdata  <= '0;
        end else begin
            rvalid <= capture;
            if (capture) begin
                rdata <= mem_rd;
            end
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-ported data memory between the MEM stage (CPU) and the debug/loader port.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int unsigned DM_ADDRESS = 9,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [DM_ADDRESS-1:0] cpu_addr,
    input  logic [DATA_W-1:0]     cpu_wdata,
    input  logic [2:0]            cpu_funct3,
    output logic                  cpu_gnt,
    output logic                  cpu_stall,
    output logic                  cpu_rvalid,
    output logic [DATA_W-1:0]     cpu_rdata,
    input  logic                  dbg_req,
    input  logic                  dbg_we,
    input  logic [DM_ADDRESS-1:0] dbg_addr,
    input  logic [DATA_W-1:0]     dbg_wdata,
    input  logic [2:0]            dbg_funct3,
    input  logic                  dbg_lock,
    output logic                  dbg_gnt,
    output logic                  dbg_rvalid,
    output logic [DATA_W-1:0]     dbg_rdata,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [DM_ADDRESS-1:0] mem_a,
    output logic [DATA_W-1:0]     mem_wd,
    output logic [2:0]            mem_funct3,
    input  logic [DATA_W-1:0]     mem_rd
);

    arb_state_t       state, state_nxt;
    logic [CNT_W-1:0] starve_cnt, starve_nxt;
    logic             starve_full;
    logic             arb_mode;
    logic             cpu_win, dbg_win;
    mem_req_t         cpu_pkt, dbg_pkt, sel_pkt;

    assign cpu_pkt = '{we: cpu_we, addr: REQ_ADDR_W'(cpu_addr), wdata: REQ_DATA_W'(cpu_wdata),
                       funct3: cpu_funct3};
    assign dbg_pkt = '{we: dbg_we, addr: REQ_ADDR_W'(dbg_addr), wdata: REQ_DATA_W'(dbg_wdata),
                       funct3: dbg_funct3};

    assign starve_full = (starve_cnt == CNT_W'(STARVE_MAX));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ARB;
            starve_cnt <= '0;
        end else begin
            state      <= state_nxt;
            starve_cnt <= starve_nxt;
        end
    end

    // A LOCK cycle with dbg_lock already low is arbitrated as ARB so the CPU can win it
    always_comb begin
        state_nxt  = state;
        starve_nxt = starve_cnt;
        cpu_win    = 1'b0;
        dbg_win    = 1'b0;
        arb_mode   = (state == ARB) || !dbg_lock;

        if (arb_mode) begin
            if (starve_full && dbg_req) begin
                dbg_win = 1'b1;
            end else if (cpu_req) begin
                cpu_win = 1'b1;
            end else if (dbg_req) begin
                dbg_win = 1'b1;
            end
        end else begin
            dbg_win = dbg_req;
        end

        if (dbg_lock && ((state == LOCK) || dbg_win)) begin
            state_nxt = LOCK;
        end else begin
            state_nxt = ARB;
        end

        if (!dbg_req || dbg_win) begin
            starve_nxt = '0;
        end else if (!starve_full) begin
            starve_nxt = starve_cnt + CNT_W'(1);
        end
    end

    // Grants are combinational, so reset must also mask them while asserted
    assign cpu_gnt   = cpu_win & reset_n;
    assign dbg_gnt   = dbg_win & reset_n;
    assign cpu_stall = cpu_req & ~cpu_gnt & reset_n;

    always_comb begin
        sel_pkt = '0;
        if (cpu_gnt) begin
            sel_pkt = cpu_pkt;
        end else if (dbg_gnt) begin
            sel_pkt = dbg_pkt;
        end
    end

    assign mem_read   = (cpu_gnt | dbg_gnt) & ~sel_pkt.we;
    assign mem_write  = (cpu_gnt | dbg_gnt) & sel_pkt.we;
    assign mem_a      = DM_ADDRESS'(sel_pkt.addr);
    assign mem_wd     = DATA_W'(sel_pkt.wdata);
    assign mem_funct3 = sel_pkt.funct3;

    dmem_rsp_reg #(.DATA_W(DATA_W)) u_cpu_rsp (
        .clk     (clk),
        .reset_n (reset_n),
        .capture (cpu_gnt & ~cpu_we),
        .mem_rd  (mem_rd),
        .rvalid  (cpu_rvalid),
        .rdata   (cpu_rdata)
    );

    dmem_rsp_reg #(.DATA_W(DATA_W)) u_dbg_rsp (
        .clk     (clk),
        .reset_n (reset_n),
        .capture (dbg_gnt & ~dbg_we),
        .mem_rd  (mem_rd),
        .rvalid  (dbg_rvalid),
        .rdata   (dbg_rdata)
    );

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with a small word-wide data memory model.
module tb_dmem_arbiter;
    import dmem_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cpu_req, cpu_we;
    logic [8:0]  cpu_addr;
    logic [31:0] cpu_wdata;
    logic [2:0]  cpu_funct3;
    logic        cpu_gnt, cpu_stall, cpu_rvalid;
    logic [31:0] cpu_rdata;
    logic        dbg_req, dbg_we, dbg_lock;
    logic [8:0]  dbg_addr;
    logic [31:0] dbg_wdata;
    logic [2:0]  dbg_funct3;
    logic        dbg_gnt, dbg_rvalid;
    logic [31:0] dbg_rdata;
    logic        mem_read, mem_write;
    logic [8:0]  mem_a;
    logic [31:0] mem_wd;
    logic [2:0]  mem_funct3;
    logic [31:0] mem_rd;

    logic [31:0] mem [0:127];
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.DM_ADDRESS(9), .DATA_W(32), .STARVE_MAX(4)) dut (
        .clk(clk), .reset_n(reset_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_funct3(cpu_funct3), .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall),
        .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_funct3(dbg_funct3), .dbg_lock(dbg_lock), .dbg_gnt(dbg_gnt),
        .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
        .mem_read(mem_read), .mem_write(mem_write), .mem_a(mem_a), .mem_wd(mem_wd),
        .mem_funct3(mem_funct3), .mem_rd(mem_rd)
    );

    // Memory commits writes on the falling edge and reads combinationally
    always @(negedge clk) begin
        if (mem_write) mem[mem_a[8:2]] <= mem_wd;
    end
    assign mem_rd = mem[mem_a[8:2]];

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_drive(input logic req, input logic we, input logic [8:0] a,
                             input logic [31:0] d, input logic [2:0] f3);
        cpu_req = req; cpu_we = we; cpu_addr = a; cpu_wdata = d; cpu_funct3 = f3;
    endtask

    task automatic dbg_drive(input logic req, input logic we, input logic [8:0] a,
                             input logic [31:0] d, input logic [2:0] f3, input logic lock);
        dbg_req = req; dbg_we = we; dbg_addr = a; dbg_wdata = d; dbg_funct3 = f3; dbg_lock = lock;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        cpu_drive(1'b1, 1'b0, 9'h010, 32'h0, F3_LW);
        dbg_drive(1'b1, 1'b0, 9'h004, 32'h0, F3_LW, 1'b0);
        #2;
        checks++;
        if ({cpu_gnt, dbg_gnt, cpu_stall} !== 3'b000) begin
            errors++; $display("FAIL reset_gnt: got %b expected 000", {cpu_gnt, dbg_gnt, cpu_stall});
        end
        checks++;
        if ({cpu_rvalid, dbg_rvalid, mem_read, mem_write} !== 4'b0000) begin
            errors++; $display("FAIL reset_strobes: got %b expected 0000",
                               {cpu_rvalid, dbg_rvalid, mem_read, mem_write});
        end
        checks++;
        if ({cpu_rdata, dbg_rdata, mem_a, mem_wd, mem_funct3} !== '0) begin
            errors++; $display("FAIL reset_buses: got %h/%h/%h/%h/%h expected all 0",
                               cpu_rdata, dbg_rdata, mem_a, mem_wd, mem_funct3);
        end
        next_cycle();
        cpu_drive(1'b0, 1'b0, 9'h0, 32'h0, 3'b000);
        dbg_drive(1'b0, 1'b0, 9'h0, 32'h0, 3'b000, 1'b0);
        next_cycle();
        reset_n = 1'b1;
    endtask

    task automatic test_cpu_only();
        next_cycle();
        cpu_drive(1'b1, 1'b1, 9'h010, 32'hDEADBEEF, F3_SW);
        #1;
        checks++;
        if ({cpu_gnt, dbg_gnt, mem_write, mem_read, mem_a} !== {4'b1010, 9'h010}) begin
            errors++; $display("FAIL cpu_sw: got gnt=%b dgnt=%b w=%b r=%b a=%h expected 1 0 1 0 010",
                               cpu_gnt, dbg_gnt, mem_write, mem_read, mem_a);
        end
        next_cycle();
        cpu_drive(1'b1, 1'b0, 9'h010, 32'h0, F3_LW);
        #1;
        checks++;
        if ({cpu_gnt, mem_read, cpu_rvalid} !== 3'b110) begin
            errors++; $display("FAIL cpu_lw: got gnt/read/rvalid=%b expected 110",
                               {cpu_gnt, mem_read, cpu_rvalid});
        end
        next_cycle();
        cpu_drive(1'b0, 1'b0, 9'h0, 32'h0, 3'b000);
        #1;
        checks++;
        if ({cpu_rvalid, dbg_rvalid, cpu_rdata} !== {2'b10, 32'hDEADBEEF}) begin
            errors++; $display("FAIL cpu_rdata: got rv=%b drv=%b rdata=%h expected 1 0 deadbeef",
                               cpu_rvalid, dbg_rvalid, cpu_rdata);
        end
        next_cycle();
        #1;
        checks++;
        if ({cpu_rvalid, cpu_rdata} !== {1'b0, 32'hDEADBEEF}) begin
            errors++; $display("FAIL cpu_rdata_hold: got rv=%b rdata=%h expected 0 deadbeef",
                               cpu_rvalid, cpu_rdata);
        end
    endtask

    task automatic test_contention();
        logic [2:0] exp;
        for (int i = 0; i < 6; i++) begin
            next_cycle();
            cpu_drive(1'b1, 1'b0, 9'h000, 32'h0, F3_LW);
            dbg_drive(1'b1, 1'b0, 9'h004, 32'h0, F3_LW, 1'b0);
            #1;
            exp = (i == 4) ? 3'b011 : 3'b100;
            checks++;
            if ({cpu_gnt, dbg_gnt, cpu_stall} !== exp) begin
                errors++; $display("FAIL contention_c%0d: got cgnt/dgnt/stall=%b expected %b",
                                   i, {cpu_gnt, dbg_gnt, cpu_stall}, exp);
            end
        end
        next_cycle();
        cpu_drive(1'b0, 1'b0, 9'h0, 32'h0, 3'b000);
        dbg_drive(1'b0, 1'b0, 9'h0, 32'h0, 3'b000, 1'b0);
    endtask

    task automatic test_lock();
        logic [2:0] exp;
        next_cycle();
        dbg_drive(1'b1, 1'b1, 9'h100, 32'h11, F3_SB, 1'b1);
        #1;
        checks++;
        if ({cpu_gnt, dbg_gnt} !== 2'b01) begin
            errors++; $display("FAIL lock_enter: got cgnt/dgnt=%b expected 01", {cpu_gnt, dbg_gnt});
        end
        // 3 more SBs, one idle lock cycle, then dbg_lock falls
        for (int i = 1; i <= 5; i++) begin
            next_cycle();
            cpu_drive(1'b1, 1'b0, 9'h010, 32'h0, F3_LW);
            if (i <= 3) dbg_drive(1'b1, 1'b1, 9'(9'h100 + i), 32'(i), F3_SB, 1'b1);
            else if (i == 4) dbg_drive(1'b0, 1'b0, 9'h0, 32'h0, 3'b000, 1'b1);
            else dbg_drive(1'b0, 1'b0, 9'h0, 32'h0, 3'b000, 1'b0);
            #1;
            exp = (i <= 3) ? 3'b011 : (i == 4) ? 3'b001 : 3'b100;
            checks++;
            if ({cpu_gnt, dbg_gnt, cpu_stall} !== exp) begin
                errors++; $display("FAIL lock_c%0d: got cgnt/dgnt/stall=%b expected %b",
                                   i, {cpu_gnt, dbg_gnt, cpu_stall}, exp);
            end
        end
        next_cycle();
        cpu_drive(1'b0, 1'b0, 9'h0, 32'h0, 3'b000);
    endtask

    task automatic test_simul_loads();
        next_cycle();
        cpu_drive(1'b1, 1'b0, 9'h020, 32'h0, F3_LW);
        dbg_drive(1'b1, 1'b0, 9'h024, 32'h0, F3_LW, 1'b0);
        #1;
        checks++;
        if ({cpu_gnt, dbg_gnt, mem_a} !== {2'b10, 9'h020}) begin
            errors++; $display("FAIL simul_n: got cgnt=%b dgnt=%b a=%h expected 1 0 020",
                               cpu_gnt, dbg_gnt, mem_a);
        end
        next_cycle();
        cpu_drive(1'b0, 1'b0, 9'h0, 32'h0, 3'b000);
        #1;
        checks++;
        if ({dbg_gnt, mem_a, cpu_rvalid, dbg_rvalid, cpu_rdata} !== {1'b1, 9'h024, 2'b10, 32'hC0DE0020}) begin
            errors++; $display("FAIL simul_n1: got dgnt=%b a=%h crv=%b drv=%b crdata=%h expected 1 024 1 0 c0de0020",
                               dbg_gnt, mem_a, cpu_rvalid, dbg_rvalid, cpu_rdata);
        end
        next_cycle();
        dbg_drive(1'b0, 1'b0, 9'h0, 32'h0, 3'b000, 1'b0);
        #1;
        checks++;
        if ({cpu_rvalid, dbg_rvalid, dbg_rdata, cpu_rdata} !== {2'b01, 32'hDB600024, 32'hC0DE0020}) begin
            errors++; $display("FAIL simul_n2: got crv=%b drv=%b drdata=%h crdata=%h expected 0 1 db600024 c0de0020",
                               cpu_rvalid, dbg_rvalid, dbg_rdata, cpu_rdata);
        end
    endtask

    task automatic test_reset_mid();
        next_cycle();
        cpu_drive(1'b1, 1'b0, 9'h024, 32'h0, F3_LW);
        #1;
        checks++;
        if (cpu_gnt !== 1'b1) begin
            errors++; $display("FAIL rstmid_pre: got cpu_gnt=%b expected 1", cpu_gnt);
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if ({cpu_gnt, cpu_stall, mem_read, mem_a, cpu_rdata, dbg_rdata} !== '0) begin
            errors++; $display("FAIL rstmid_out: got gnt=%b stall=%b rd=%b a=%h crd=%h drd=%h expected all 0",
                               cpu_gnt, cpu_stall, mem_read, mem_a, cpu_rdata, dbg_rdata);
        end
        next_cycle();
        checks++;
        if ({cpu_rvalid, dbg_rvalid} !== 2'b00) begin
            errors++; $display("FAIL rstmid_rvalid: got %b expected 00", {cpu_rvalid, dbg_rvalid});
        end
        reset_n = 1'b1;
        cpu_drive(1'b0, 1'b0, 9'h0, 32'h0, 3'b000);
        dbg_drive(1'b1, 1'b1, 9'h030, 32'h5, F3_SW, 1'b1);
        #1;
        checks++;
        if ({dbg_gnt, mem_write} !== 2'b11) begin
            errors++; $display("FAIL rstmid_first: got dgnt/write=%b expected 11", {dbg_gnt, mem_write});
        end
        next_cycle();
        cpu_drive(1'b1, 1'b0, 9'h010, 32'h0, F3_LW);
        dbg_drive(1'b0, 1'b0, 9'h0, 32'h0, 3'b000, 1'b1);
        #1;
        checks++;
        if (cpu_gnt !== 1'b0) begin
            errors++; $display("FAIL lock_hold: got cpu_gnt=%b expected 0", cpu_gnt);
        end
        reset_n = 1'b0;
        #1;
        reset_n = 1'b1;
        #1;
        checks++;
        if (cpu_gnt !== 1'b1) begin
            errors++; $display("FAIL rst_to_arb: got cpu_gnt=%b expected 1", cpu_gnt);
        end
        next_cycle();
        cpu_drive(1'b0, 1'b0, 9'h0, 32'h0, 3'b000);
        dbg_drive(1'b0, 1'b0, 9'h0, 32'h0, 3'b000, 1'b0);
    endtask

    task automatic test_store();
        next_cycle();
        dbg_drive(1'b1, 1'b1, 9'h006, 32'h0000ABCD, F3_SH, 1'b0);
        #1;
        checks++;
        if ({dbg_gnt, mem_write, mem_read, mem_a, mem_funct3, mem_wd} !==
            {3'b110, 9'h006, 3'b001, 32'h0000ABCD}) begin
            errors++; $display("FAIL store_pass: got g=%b w=%b r=%b a=%h f3=%b wd=%h expected 1 1 0 006 001 0000abcd",
                               dbg_gnt, mem_write, mem_read, mem_a, mem_funct3, mem_wd);
        end
        next_cycle();
        dbg_drive(1'b0, 1'b0, 9'h0, 32'h0, 3'b000, 1'b0);
        #1;
        checks++;
        if ({dbg_rvalid, mem_write} !== 2'b00) begin
            errors++; $display("FAIL store_norvalid: got rvalid/write=%b expected 00", {dbg_rvalid, mem_write});
        end
    endtask

    initial begin
        for (int i = 0; i < 128; i++) mem[i] = 32'h0;
        mem[1] = 32'h04040404;
        mem[8] = 32'hC0DE0020;
        mem[9] = 32'hDB600024;
        test_reset();
        test_cpu_only();
        test_contention();
        test_lock();
        test_simul_loads();
        test_reset_mid();
        test_store();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
